// File: rtl/prog_mem_loader.sv
// prog_mem_loader: synchronous-read program memory with a streaming load
// engine. Optional parity storage/check enabled by PROG_MEM_PARITY_EN.
// Ports:
//   clk, rst_n (async, active low)
//   fetch_req/fetch_addr -> fetch_data/fetch_valid (1-cycle latency)
//   fetch_data/fetch_valid hold or drop while a load is in progress
//   load_start, load_valid/load_data/load_last -> load_ready
//   load_done (1-cycle pulse), load_count, busy, parity_err
module prog_mem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_valid,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  busy,
  output logic                  parity_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;
  logic                  wr_en;
  logic                  rd_en;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    load_ready = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      IDLE, READY: begin
        if (load_start) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (load_valid) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          // last beat or top of memory ends the load; pointer never wraps
          if (load_last || (&wr_ptr_q)) begin
            state_d  = READY;
            done_d   = 1'b1;
            wr_ptr_d = wr_ptr_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en = busy & load_valid;
  // fetch is blocked during a load, so no read-during-write case exists
  assign rd_en = fetch_req & (state_q != LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      rvalid_q <= rd_en;
      if (rd_en) begin
        rdata_q <= mem_q[fetch_addr];
      end
    end
  end

  // array contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= load_data;
    end
  end

`ifdef PROG_MEM_PARITY_EN
  logic par_q [DEPTH];
  logic perr_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      par_q[wr_ptr_q] <= ^load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else if (rd_en) begin
      perr_q <= (^mem_q[fetch_addr]) ^ par_q[fetch_addr];
    end else begin
      perr_q <= 1'b0;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign fetch_data  = rdata_q;
  assign fetch_valid = rvalid_q;
  assign load_done   = done_q;
  assign load_count  = cnt_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: directed stimulus with a fetch scoreboard.
// Second instance at ADDR_WIDTH=4 covers the memory-full boundary.
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [7:0]  fetch_addr = '0;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        load_done;
  logic [8:0]  load_count;
  logic        busy;
  logic        parity_err;

  logic        fetch_req4 = 1'b0;
  logic [3:0]  fetch_addr4 = '0;
  logic [31:0] fetch_data4;
  logic        fetch_valid4;
  logic        load_start4 = 1'b0;
  logic        load_valid4 = 1'b0;
  logic [31:0] load_data4 = '0;
  logic        load_last4 = 1'b0;
  logic        load_ready4;
  logic        load_done4;
  logic [4:0]  load_count4;
  logic        busy4;
  logic        parity_err4;

  int cmp = 0;
  int err = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prog_mem_loader dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_done(load_done),
    .load_count(load_count), .busy(busy),
    .parity_err(parity_err)
  );

  prog_mem_loader #(.ADDR_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req4), .fetch_addr(fetch_addr4),
    .fetch_data(fetch_data4), .fetch_valid(fetch_valid4),
    .load_start(load_start4), .load_valid(load_valid4),
    .load_data(load_data4), .load_last(load_last4),
    .load_ready(load_ready4), .load_done(load_done4),
    .load_count(load_count4), .busy(busy4),
    .parity_err(parity_err4)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(logic [31:0] d);
    exp_t e;
    e.d   = d;
    e.due = cyc + 1;
    q.push_back(e);
  endtask

  // monitor: every presented fetch result must match the queue head
  always @(negedge clk) begin
    if (rst_n && fetch_valid) begin
      if (q.size() == 0) begin
        cmp++;
        err++;
        $display("FAIL fetch_unexpected: got valid data %h want none",
                 fetch_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("fetch_data", 64'(fetch_data), 64'(e.d));
        chk("fetch_lat", 64'(cyc), 64'(e.due));
        chk("parity_err", 64'(parity_err), 64'd0);
      end
    end
  end

  initial begin
    int acc;
    int dn;
    int wt;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_fetch", {fetch_data, 31'd0, fetch_valid}, 64'd0);
    chk("rst_load", {load_ready, load_done, load_count, busy, parity_err},
        64'd0);
    chk("rst_ready4", {load_ready4, busy4, load_count4}, 64'd0);

    // program load with one bubble
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("load_busy", {busy, load_ready}, 64'h3);
    load_valid = 1'b1;
    load_data  = 32'h0000_0013;
    @(negedge clk);
    load_data  = 32'h0050_0093;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    chk("bubble_done", 64'(load_done), 64'd0);
    load_valid = 1'b1;
    load_data  = 32'h00A0_0113;
    load_last  = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("done_pulse", 64'(load_done), 64'd1);
    chk("done_count", 64'(load_count), 64'd3);
    chk("done_busy", {busy, load_ready}, 64'd0);
    @(negedge clk);
    chk("done_clear", 64'(load_done), 64'd0);
    chk("count_hold", 64'(load_count), 64'd3);

    // back-to-back fetches
    fetch_req = 1'b1;
    fetch_addr = 8'd0;
    push(32'h0000_0013);
    @(negedge clk);
    fetch_addr = 8'd1;
    push(32'h0050_0093);
    @(negedge clk);
    fetch_addr = 8'd2;
    push(32'h00A0_0113);
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    chk("fetch_drop", 64'(fetch_valid), 64'd0);
    chk("fetch_hold", 64'(fetch_data), 64'h00A0_0113);

    // fetch blocked in LOAD, then reset mid-load
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 8'd0;
    load_valid = 1'b1;
    load_data  = 32'h1111_1111;
    @(negedge clk);
    chk("blk_valid", 64'(fetch_valid), 64'd0);
    chk("blk_data", 64'(fetch_data), 64'h00A0_0113);
    load_data = 32'h2222_2222;
    @(negedge clk);
    chk("blk_valid2", 64'(fetch_valid), 64'd0);
    chk("mid_count", 64'(load_count), 64'd2);
    rst_n      = 1'b0;
    load_valid = 1'b0;
    fetch_req  = 1'b0;
    #1;
    chk("arst_count", 64'(load_count), 64'd0);
    chk("arst_busy", {busy, load_ready, fetch_valid}, 64'd0);
    chk("arst_data", 64'(fetch_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {busy, load_ready}, 64'd0);
    fetch_req  = 1'b1;
    fetch_addr = 8'd1;
    push(32'h2222_2222);
    @(negedge clk);
    fetch_req = 1'b0;

    // overflow on the 16-word instance
    load_start4 = 1'b1;
    @(negedge clk);
    load_start4 = 1'b0;
    acc = 0;
    dn  = 0;
    for (int i = 0; i < 22; i++) begin
      if (load_done4) dn++;
      load_valid4 = (i < 20);
      load_data4  = 32'h100 + 32'(acc);
      if (load_valid4 && load_ready4) acc++;
      @(negedge clk);
    end
    load_valid4 = 1'b0;
    chk("ovf_accepted", 64'(acc), 64'd16);
    chk("ovf_count", 64'(load_count4), 64'd16);
    chk("ovf_ready", {load_ready4, busy4}, 64'd0);
    chk("ovf_done", 64'(dn), 64'd1);
    fetch_req4  = 1'b1;
    fetch_addr4 = 4'd15;
    @(negedge clk);
    fetch_req4 = 1'b0;
    chk("ovf_fetch", {fetch_valid4, fetch_data4}, {1'b1, 32'h10F});
    chk("ovf_perr", 64'(parity_err4), 64'd0);

    wt = 0;
    while (q.size() != 0 && wt < 10) begin
      @(negedge clk);
      wt++;
    end
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- Parametrised successor to the asynchronous instruction RAM: synchronous-read program memory with a built-in streaming load engine.
- A host streams instruction words in over a valid/ready port; the core fetches over a registered read port with 1-cycle latency.
- Sits between the boot/testbench program source and the CPU fetch stage. Replaces the combinational RAM, so the fetch stage must tolerate 1-cycle latency.

Parameters:
- ADDR_WIDTH, 8, word-address width; depth DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction word width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  read request this cycle.
- fetch_addr  in  ADDR_WIDTH  word address (PC[ADDR_WIDTH+1:2]).
- fetch_data  out  DATA_WIDTH  registered read data.
- fetch_valid  out  1  fetch_data valid for the request of the previous cycle.
- load_start  in  1  begin a new program load at address 0.
- load_valid  in  1  load_data/load_last valid.
- load_data  in  DATA_WIDTH  word to write.
- load_last  in  1  final word of program.
- load_ready  out  1  engine accepts a beat.
- load_done  out  1  one-cycle pulse when a load completes.
- load_count  out  ADDR_WIDTH+1  words written by the last/current load.
- busy  out  1  high while in LOAD.
- parity_err  out  1  see Optional Feature.

Behaviour:
- Reset values: fetch_data=0, fetch_valid=0, load_ready=0, load_done=0, load_count=0, busy=0, parity_err=0, state=IDLE, wr_ptr=0.
- Memory array is never reset; contents survive rst_n.
- FSM states:
  - IDLE: load_start -> LOAD, wr_ptr=0, load_count=0.
  - LOAD: load_ready=1, busy=1. Each accepted beat (load_valid & load_ready) writes mem[wr_ptr]=load_data, then wr_ptr+1 and load_count+1.
    - Accepted beat with load_last=1 -> READY, with load_done=1 for the next cycle only.
    - Accepted beat at wr_ptr=DEPTH-1 without last -> also READY with load_done (load_count=DEPTH). wr_ptr never wraps.
    - load_start while in LOAD is ignored.
  - READY: load_start -> LOAD (restart at 0, load_count cleared). Otherwise hold.
- load_ready and busy are combinational from state (LOAD). load_ready is 0 in IDLE and READY.
- Fetch: sampled at the clock edge. If fetch_req=1 and state!=LOAD, the next cycle gives fetch_data=mem[fetch_addr] and fetch_valid=1.
  - If fetch_req=0, or state==LOAD at sample time: fetch_valid=0 next cycle and fetch_data holds its previous value.
- Fetch is serviced in IDLE, returning uninitialised contents; this is legal, and the core is held off until load_done.
- Back-to-back fetches give one result per cycle.
- Same-cycle load write and fetch are impossible because fetch is blocked in LOAD; no read-during-write hazard exists.
- rst_n asserted mid-load: immediate return to IDLE, all outputs to reset values. Words already written stay in memory.
- load_count saturates at DEPTH and holds after load_done until the next load_start.

Optional Feature:
- Macro: PROG_MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed on write.
  - On a serviced fetch, the parity of the read word plus the stored bit is checked. parity_err=1 is registered alongside fetch_valid=1 on mismatch, else 0.
  - parity_err is 0 whenever fetch_valid=0.
- Undefined: no parity storage; parity_err tied to 0.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, load_ready=0, busy=0.
- load_start, then stream 0x00000013, 0x00500093, 0x00A00113 (last on 3rd), with one load_valid=0 bubble -> load_done pulses once 1 cycle after 3rd beat, load_count=3, busy low after.
- After load, fetch addr 0,1,2 back-to-back -> fetch_data 0x00000013, 0x00500093, 0x00A00113 on consecutive cycles, fetch_valid=1 each, 1-cycle latency.
- fetch_req held high during LOAD -> fetch_valid=0, fetch_data unchanged. Assert rst_n=0 after 2 beats -> IDLE, load_count=0; fetch addr 1 afterward returns the 2nd beat.
- ADDR_WIDTH=4: stream 20 words, no last -> exactly 16 accepted, load_ready drops, load_count=16, load_done once.
- PROG_MEM_PARITY_EN: load word 0x0000000F, force-flip stored bit 0, fetch addr 0 -> fetch_valid=1, parity_err=1. An unflipped word gives parity_err=0.
